logic_response_checker: RTL and testbench

- Hardware response checker for small combinational blocks such as the AND gate.
- Sits on the output side of the DUT and receives each applied input vector with the DUT output it produced.
- Compares each sample against a parameterised truth table and counts mismatches.
- Tracks which input combinations have been exercised and reports pass/fail, so a stimulus source and this block form a self-checking loop without a simulator-only bench.

---
 rtl/logic_response_checker.sv | 186 ++++++++++++++++++
 tb/tb_logic_response_checker.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_response_checker.sv
// ---------------------------------------------------------------------------
// logic_response_checker
//
// Purpose:
//   Hardware response checker for small combinational blocks (default: a
//   2-input AND gate). Each accepted sample pairs the input code applied to
//   the block under test with the output it produced. The sample is compared
//   against the TRUTH table and mismatches are counted. The checker also
//   records which input codes have been exercised. A run ends in DONE with a
//   pass/fail verdict, either when every code has been seen or when the
//   stimulus source goes quiet for TIMEOUT cycles.
//
// Ports:
//   i_clk              clock, all logic on the rising edge
//   i_rst_n            synchronous reset, active HIGH (asserted = 1)
//   i_start            begin a run (sampled in IDLE and DONE only)
//   i_vec_valid        i_vec_in / i_dut_out pair is valid this cycle
//   i_vec_in           input code that was applied to the block under test
//   i_dut_out          response of the block under test to i_vec_in
//   o_vec_ready        checker accepts a sample this cycle (RUN only)
//   o_busy             high in RUN
//   o_done             high in DONE
//   o_pass             verdict, valid while o_done = 1
//   o_timeout          run ended because of inactivity
//   o_err_count        saturating mismatch count
//   o_coverage         bit i set once code i has been accepted
//   o_first_fail_valid at least one mismatch has been recorded
//   o_first_fail_vec   code of the first mismatch
// ---------------------------------------------------------------------------
module logic_response_checker #(
    parameter int                   IN_W    = 2,
    parameter logic [2**IN_W-1:0]   TRUTH   = 4'b1000,
    parameter int                   TIMEOUT = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_vec_valid,
    input  logic [IN_W-1:0]     i_vec_in,
    input  logic                i_dut_out,
    output logic                o_vec_ready,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic                o_timeout,
    output logic [7:0]          o_err_count,
    output logic [2**IN_W-1:0]  o_coverage,
    output logic                o_first_fail_valid,
    output logic [IN_W-1:0]     o_first_fail_vec
);

    localparam int                 COV_W   = 2**IN_W;
    localparam int                 CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [7:0]          r_errCount;
    logic [COV_W-1:0]    r_coverage;
    logic                r_firstFailValid;
    logic [IN_W-1:0]     r_firstFailVec;
    logic                r_timeout;
    logic                r_pass;
    logic [CNT_W-1:0]    r_idleCnt;

    logic                w_accept;
    logic                w_mismatch;
    logic [COV_W-1:0]    w_covNext;
    logic [7:0]          w_errNext;
    logic                w_timeoutHit;

    // Sample acceptance and the status values this cycle's sample would
    // produce. The DONE decision and the pass verdict both look at these
    // "after this sample" values so the final sample counts on the same edge.
    assign w_accept     = (r_state == RUN) && i_vec_valid;
    assign w_mismatch   = w_accept && (i_dut_out != TRUTH[i_vec_in]);
    assign w_covNext    = w_accept ? (r_coverage | (COV_W'(1) << i_vec_in)) : r_coverage;
    assign w_errNext    = (w_mismatch && (r_errCount != 8'hFF)) ? (r_errCount + 8'd1) : r_errCount;
    assign w_timeoutHit = (r_state == RUN) && !w_accept && (r_idleCnt == TO_LAST);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and the state-decoded handshake/status outputs.
    // start is only honoured outside RUN; in RUN the run ends on full
    // coverage or on the inactivity limit.
    always_comb begin
        w_nextState = r_state;
        o_busy      = 1'b0;
        o_vec_ready = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                o_busy      = 1'b1;
                o_vec_ready = 1'b1;
                if ((&w_covNext) || w_timeoutHit) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                o_done = 1'b1;
                if (i_start) begin
                    w_nextState = RUN;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Status datapath. A start (from IDLE or DONE) wipes the previous run's
    // results. In RUN each accepted sample updates coverage, the saturating
    // error count and the first-failure capture, and clears the inactivity
    // counter. The verdict is latched on the edge that enters DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            r_errCount       <= '0;
            r_coverage       <= '0;
            r_firstFailValid <= 1'b0;
            r_firstFailVec   <= '0;
            r_timeout        <= 1'b0;
            r_pass           <= 1'b0;
            r_idleCnt        <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_errCount       <= '0;
                        r_coverage       <= '0;
                        r_firstFailValid <= 1'b0;
                        r_firstFailVec   <= '0;
                        r_timeout        <= 1'b0;
                        r_pass           <= 1'b0;
                        r_idleCnt        <= '0;
                    end
                end
                RUN: begin
                    r_coverage <= w_covNext;
                    r_errCount <= w_errNext;
                    if (w_mismatch && !r_firstFailValid) begin
                        r_firstFailValid <= 1'b1;
                        r_firstFailVec   <= i_vec_in;
                    end
                    if (w_accept) begin
                        r_idleCnt <= '0;
                    end else begin
                        r_idleCnt <= r_idleCnt + CNT_W'(1);
                    end
                    if (w_nextState == DONE) begin
                        r_timeout <= w_timeoutHit;
                        r_pass    <= (w_errNext == 8'd0) && (&w_covNext) && !w_timeoutHit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_pass             = r_pass;
    assign o_timeout          = r_timeout;
    assign o_err_count        = r_errCount;
    assign o_coverage         = r_coverage;
    assign o_first_fail_valid = r_firstFailValid;
    assign o_first_fail_vec   = r_firstFailVec;

endmodule

// File: tb/tb_logic_response_checker.sv
// ---------------------------------------------------------------------------
// tb_logic_response_checker
//
// Directed bench for logic_response_checker with the default AND truth
// table. Inputs change 1 time unit after the rising edge. Outputs are also
// sampled there, once the edge's register updates have settled.
// ---------------------------------------------------------------------------
module tb_logic_response_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic       vecValid;
    logic [1:0] vecIn;
    logic       dutOut;
    logic       vecReady;
    logic       busy;
    logic       done;
    logic       pass;
    logic       timeoutFlag;
    logic [7:0] errCount;
    logic [3:0] coverage;
    logic       firstFailValid;
    logic [1:0] firstFailVec;

    int passCount  = 0;
    int checkCount = 0;

    logic_response_checker #(
        .IN_W    (2),
        .TRUTH   (4'b1000),
        .TIMEOUT (16)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst),
        .i_start            (start),
        .i_vec_valid        (vecValid),
        .i_vec_in           (vecIn),
        .i_dut_out          (dutOut),
        .o_vec_ready        (vecReady),
        .o_busy             (busy),
        .o_done             (done),
        .o_pass             (pass),
        .o_timeout          (timeoutFlag),
        .o_err_count        (errCount),
        .o_coverage         (coverage),
        .o_first_fail_valid (firstFailValid),
        .o_first_fail_vec   (firstFailVec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for exactly one cycle.
    task automatic applyStimulus(input logic [1:0] v, input logic o);
        vecValid = 1'b1;
        vecIn    = v;
        dutOut   = o;
        step();
        vecValid = 1'b0;
    endtask

    task automatic startRun();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic cleanSweep();
        applyStimulus(2'b00, 1'b0);
        applyStimulus(2'b01, 1'b0);
        applyStimulus(2'b10, 1'b0);
        applyStimulus(2'b11, 1'b1);
    endtask

    // Reset from power-up: every output must read zero.
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checkCount++;
        if ({vecReady, busy, done, pass, timeoutFlag, firstFailValid} !== 6'b0)
            $display("[TB] FAIL reset_flags got %b want 000000", {vecReady, busy, done, pass, timeoutFlag, firstFailValid});
        else passCount++;
        checkCount++;
        if ({errCount, coverage, firstFailVec} !== 14'd0)
            $display("[TB] FAIL reset_status got err=%0d cov=%b ffv=%b want 0", errCount, coverage, firstFailVec);
        else passCount++;
        step();
        checkCount++;
        if ({busy, done} !== 2'b00)
            $display("[TB] FAIL idle_hold got busy/done=%b want 00", {busy, done});
        else passCount++;
    endtask

    // Clean AND sweep: done appears one cycle after the 4th sample.
    task automatic test_and_sweep();
        startRun();
        checkCount++;
        if ({busy, vecReady, done} !== 3'b110)
            $display("[TB] FAIL sweep_run got busy/ready/done=%b want 110", {busy, vecReady, done});
        else passCount++;
        applyStimulus(2'b00, 1'b0);
        applyStimulus(2'b01, 1'b0);
        applyStimulus(2'b10, 1'b0);
        checkCount++;
        if ({done, coverage} !== 5'b0_0111)
            $display("[TB] FAIL sweep_mid got done/cov=%b want 00111", {done, coverage});
        else passCount++;
        applyStimulus(2'b11, 1'b1);
        checkCount++;
        if ({done, pass, busy, vecReady, timeoutFlag, firstFailValid} !== 6'b110000)
            $display("[TB] FAIL sweep_done got %b want 110000", {done, pass, busy, vecReady, timeoutFlag, firstFailValid});
        else passCount++;
        checkCount++;
        if ({errCount, coverage} !== {8'd0, 4'b1111})
            $display("[TB] FAIL sweep_status got err=%0d cov=%b want err=0 cov=1111", errCount, coverage);
        else passCount++;
    endtask

    // Sweep with code 10 answering 1 (should be 0).
    task automatic test_fault();
        startRun();
        applyStimulus(2'b00, 1'b0);
        applyStimulus(2'b01, 1'b0);
        applyStimulus(2'b10, 1'b1);
        applyStimulus(2'b11, 1'b1);
        checkCount++;
        if ({done, pass, firstFailValid, firstFailVec} !== 5'b10110)
            $display("[TB] FAIL fault_flags got done/pass/ffv/vec=%b want 10110", {done, pass, firstFailValid, firstFailVec});
        else passCount++;
        checkCount++;
        if ({errCount, coverage} !== {8'd1, 4'b1111})
            $display("[TB] FAIL fault_status got err=%0d cov=%b want err=1 cov=1111", errCount, coverage);
        else passCount++;
    endtask

    // Restart from DONE clears results; a clean sweep then passes.
    task automatic test_restart();
        startRun();
        checkCount++;
        if ({busy, done, firstFailValid, errCount, coverage} !== 15'b100_00000000_0000)
            $display("[TB] FAIL restart_clear got busy=%b done=%b ffv=%b err=%0d cov=%b want busy=1 rest 0",
                     busy, done, firstFailValid, errCount, coverage);
        else passCount++;
        cleanSweep();
        checkCount++;
        if ({done, pass, errCount} !== {2'b11, 8'd0})
            $display("[TB] FAIL restart_sweep got done=%b pass=%b err=%0d want 1 1 0", done, pass, errCount);
        else passCount++;
    endtask

    // Two accepts, then silence: done exactly 16 cycles after the 2nd accept.
    task automatic test_timeout();
        int waited;
        startRun();
        applyStimulus(2'b00, 1'b0);
        applyStimulus(2'b01, 1'b0);
        waited = 0;
        while (done !== 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        checkCount++;
        if (waited !== 16)
            $display("[TB] FAIL timeout_latency got %0d cycles want 16", waited);
        else passCount++;
        checkCount++;
        if ({done, timeoutFlag, pass, vecReady, busy, coverage} !== 9'b11000_0011)
            $display("[TB] FAIL timeout_status got done/to/pass/ready/busy/cov=%b want 110000011",
                     {done, timeoutFlag, pass, vecReady, busy, coverage});
        else passCount++;
        // Samples offered in DONE are ignored.
        applyStimulus(2'b11, 1'b0);
        checkCount++;
        if ({done, coverage, errCount} !== {1'b1, 4'b0011, 8'd0})
            $display("[TB] FAIL done_ignore got done=%b cov=%b err=%0d want 1 0011 0", done, coverage, errCount);
        else passCount++;
        // start wins over a simultaneous sample.
        start    = 1'b1;
        vecValid = 1'b1;
        vecIn    = 2'b11;
        dutOut   = 1'b0;
        step();
        start    = 1'b0;
        vecValid = 1'b0;
        checkCount++;
        if ({busy, done, timeoutFlag, coverage, errCount} !== {3'b100, 4'b0000, 8'd0})
            $display("[TB] FAIL start_drop got busy=%b done=%b to=%b cov=%b err=%0d want 1 0 0 0000 0",
                     busy, done, timeoutFlag, coverage, errCount);
        else passCount++;
    endtask

    // Reset during a run (entered from the previous task, still in RUN).
    task automatic test_reset_midrun();
        applyStimulus(2'b00, 1'b0);
        applyStimulus(2'b01, 1'b1);
        checkCount++;
        if ({busy, errCount, firstFailValid, firstFailVec} !== {1'b1, 8'd1, 1'b1, 2'b01})
            $display("[TB] FAIL midrun_pre got busy=%b err=%0d ffv=%b vec=%b want 1 1 1 01",
                     busy, errCount, firstFailValid, firstFailVec);
        else passCount++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkCount++;
        if ({vecReady, busy, done, pass, timeoutFlag, firstFailValid, errCount, coverage, firstFailVec} !== 20'd0)
            $display("[TB] FAIL midrun_reset got ready=%b busy=%b done=%b pass=%b to=%b ffv=%b err=%0d cov=%b vec=%b want all 0",
                     vecReady, busy, done, pass, timeoutFlag, firstFailValid, errCount, coverage, firstFailVec);
        else passCount++;
        startRun();
        cleanSweep();
        checkCount++;
        if ({done, pass, errCount} !== {2'b11, 8'd0})
            $display("[TB] FAIL midrun_sweep got done=%b pass=%b err=%0d want 1 1 0", done, pass, errCount);
        else passCount++;
    endtask

    // 300 mismatches on code 00, every other cycle: count saturates at 255.
    task automatic test_saturation();
        startRun();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(2'b00, 1'b1);
            if (i == 253) begin
                checkCount++;
                if (errCount !== 8'd254)
                    $display("[TB] FAIL sat_254 got %0d want 254", errCount);
                else passCount++;
            end
            if (i == 254) begin
                checkCount++;
                if (errCount !== 8'd255)
                    $display("[TB] FAIL sat_255 got %0d want 255", errCount);
                else passCount++;
            end
            step();
        end
        checkCount++;
        if ({busy, done, errCount} !== {2'b10, 8'd255})
            $display("[TB] FAIL sat_hold got busy=%b done=%b err=%0d want 1 0 255", busy, done, errCount);
        else passCount++;
        applyStimulus(2'b01, 1'b0);
        applyStimulus(2'b10, 1'b0);
        applyStimulus(2'b11, 1'b1);
        checkCount++;
        if ({done, pass, firstFailValid, firstFailVec, errCount} !== {5'b10100, 8'd255})
            $display("[TB] FAIL sat_final got done=%b pass=%b ffv=%b vec=%b err=%0d want 1 0 1 00 255",
                     done, pass, firstFailValid, firstFailVec, errCount);
        else passCount++;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        vecValid = 1'b0;
        vecIn    = 2'b00;
        dutOut   = 1'b0;
        #1;
        test_reset();
        test_and_sweep();
        test_fault();
        test_restart();
        test_timeout();
        test_reset_midrun();
        test_saturation();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Hard stop in case the run somehow stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule
